audio_codec_config: RTL and testbench

// - Power-up configuration sequencer for the WM8731 codec behind the audio_codec serial datapath.
// - Writes a fixed 11-entry register table through the I2C master using a req/done handshake.
// - Retries NACKed writes, then raises cfg_done so the top level can ungate audio.
// - Optionally services runtime headphone-volume writes after configuration completes.

---
 rtl/audio_codec_config.sv | 277 +++++++++++++++++++++++++++
 tb/tb_audio_codec_config.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_config.sv
// Power-up sequencer that writes the WM8731 register table through an I2C req/done master.
// Define AUDIO_CFG_VOLUME_EN to build runtime headphone-volume writes after configuration.
module audio_codec_config #(
    parameter logic [6:0] DEVICE_ADDR   = 7'h1A,
    parameter int         POWERUP_DELAY = 50000,
    parameter int         BACKOFF       = 1000,
    parameter int         MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    input  logic        vol_wr,
    input  logic [6:0]  vol_val
);
    localparam logic [31:0] PWR_LAST  = 32'(POWERUP_DELAY - 1);
    localparam logic [31:0] BO_LAST   = 32'(BACKOFF - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [3:0]  LAST_IDX  = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PWRUP   = 4'd1,
        S_ISSUE   = 4'd2,
        S_WAIT    = 4'd3,
        S_BACKOFF = 4'd4,
        S_DONE    = 4'd5,
        S_ERROR   = 4'd6
`ifdef AUDIO_CFG_VOLUME_EN
        ,
        S_VOL_ISSUE   = 4'd7,
        S_VOL_WAIT    = 4'd8,
        S_VOL_BACKOFF = 4'd9
`endif
    } state_t;

    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_word = 16'h1E00;
            4'd1:    cfg_word = 16'h0017;
            4'd2:    cfg_word = 16'h0217;
            4'd3:    cfg_word = 16'h0479;
            4'd4:    cfg_word = 16'h0679;
            4'd5:    cfg_word = 16'h0812;
            4'd6:    cfg_word = 16'h0A00;
            4'd7:    cfg_word = 16'h0C00;
            4'd8:    cfg_word = 16'h0E01;
            4'd9:    cfg_word = 16'h1000;
            4'd10:   cfg_word = 16'h1201;
            default: cfg_word = 16'h0000;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [3:0]  r_index;
    logic [7:0]  r_retry;
    logic        r_req;
    logic [23:0] r_data;
    logic        r_busy;
    logic        r_cfg_done;
    logic        r_cfg_error;
    logic        w_req_nxt;
    logic [23:0] w_data_nxt;
    logic        w_busy_nxt;
    logic        w_cfg_done_nxt;
    logic        w_cfg_error_nxt;
    logic        w_start_ok;
    logic        w_ack;
    logic        w_in_delay;
    logic        w_in_wait;
    logic        w_vol_pending;

    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
    assign w_ack      = i2c_done & ~i2c_nack;

`ifdef AUDIO_CFG_VOLUME_EN
    logic       r_vol_pending;
    logic       r_vol_again;
    logic [6:0] r_vol_val;
    logic       w_in_vol;

    assign w_in_vol      = (r_state == S_VOL_ISSUE) | (r_state == S_VOL_WAIT) | (r_state == S_VOL_BACKOFF);
    assign w_vol_pending = r_vol_pending;

    // Volume request latch; a request arriving mid-write is re-serviced after the ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vol_pending <= 1'b0;
            r_vol_again   <= 1'b0;
            r_vol_val     <= 7'd0;
        end else begin
            if (vol_wr) begin
                r_vol_val <= vol_val;
            end else begin
                r_vol_val <= r_vol_val;
            end
            if (vol_wr) begin
                r_vol_pending <= 1'b1;
            end else if (w_start_ok) begin
                r_vol_pending <= 1'b0;
            end else if ((r_state == S_VOL_WAIT) && w_ack) begin
                r_vol_pending <= r_vol_again;
            end else begin
                r_vol_pending <= r_vol_pending;
            end
            if (w_in_vol) begin
                r_vol_again <= r_vol_again | vol_wr;
            end else begin
                r_vol_again <= 1'b0;
            end
        end
    end
`else
    logic w_unused_vol;
    assign w_unused_vol  = ^{vol_wr, vol_val};
    assign w_vol_pending = 1'b0;
`endif

    // Classify the current state for the shared counter and retry logic.
    always_comb begin
        w_in_delay = (r_state == S_PWRUP) || (r_state == S_BACKOFF);
        w_in_wait  = (r_state == S_WAIT);
`ifdef AUDIO_CFG_VOLUME_EN
        w_in_delay = w_in_delay || (r_state == S_VOL_BACKOFF);
        w_in_wait  = w_in_wait || (r_state == S_VOL_WAIT);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_PWRUP;
                else       w_state_nxt = S_IDLE;
            end
            S_PWRUP: begin
                if (r_cnt == PWR_LAST) w_state_nxt = S_ISSUE;
                else                   w_state_nxt = S_PWRUP;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!i2c_done)                 w_state_nxt = S_WAIT;
                else if (!i2c_nack)            w_state_nxt = (r_index == LAST_IDX) ? S_DONE : S_ISSUE;
                else if (r_retry >= RETRY_MAX) w_state_nxt = S_ERROR;
                else                           w_state_nxt = S_BACKOFF;
            end
            S_BACKOFF: begin
                if (r_cnt == BO_LAST) w_state_nxt = S_ISSUE;
                else                  w_state_nxt = S_BACKOFF;
            end
            S_DONE: begin
                if (start)              w_state_nxt = S_PWRUP;
`ifdef AUDIO_CFG_VOLUME_EN
                else if (w_vol_pending) w_state_nxt = S_VOL_ISSUE;
`endif
                else                    w_state_nxt = S_DONE;
            end
            S_ERROR: begin
                if (start) w_state_nxt = S_PWRUP;
                else       w_state_nxt = S_ERROR;
            end
`ifdef AUDIO_CFG_VOLUME_EN
            S_VOL_ISSUE: w_state_nxt = S_VOL_WAIT;
            S_VOL_WAIT: begin
                if (!i2c_done)                 w_state_nxt = S_VOL_WAIT;
                else if (!i2c_nack)            w_state_nxt = S_DONE;
                else if (r_retry >= RETRY_MAX) w_state_nxt = S_ERROR;
                else                           w_state_nxt = S_VOL_BACKOFF;
            end
            S_VOL_BACKOFF: begin
                if (r_cnt == BO_LAST) w_state_nxt = S_VOL_ISSUE;
                else                  w_state_nxt = S_VOL_BACKOFF;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is registered and state-aligned.
    always_comb begin
        w_req_nxt       = 1'b0;
        w_busy_nxt      = 1'b1;
        w_cfg_done_nxt  = 1'b0;
        w_cfg_error_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE:  w_busy_nxt = 1'b0;
            S_WAIT:  w_req_nxt  = 1'b1;
            S_DONE: begin
                w_busy_nxt     = 1'b0;
                w_cfg_done_nxt = 1'b1;
            end
            S_ERROR: begin
                w_busy_nxt      = 1'b0;
                w_cfg_error_nxt = 1'b1;
            end
`ifdef AUDIO_CFG_VOLUME_EN
            S_VOL_ISSUE, S_VOL_BACKOFF: w_cfg_done_nxt = 1'b1;
            S_VOL_WAIT: begin
                w_req_nxt      = 1'b1;
                w_cfg_done_nxt = 1'b1;
            end
`endif
            default: w_busy_nxt = 1'b1;
        endcase
        if (r_state == S_ISSUE) begin
            w_data_nxt = {DEVICE_ADDR, 1'b0, cfg_word(r_index)};
        end
`ifdef AUDIO_CFG_VOLUME_EN
        else if (r_state == S_VOL_ISSUE) begin
            w_data_nxt = {DEVICE_ADDR, 1'b0, 16'h0500 | {9'd0, r_vol_val}};
        end
`endif
        else begin
            w_data_nxt = r_data;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_data      <= 24'd0;
            r_busy      <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            r_req       <= w_req_nxt;
            r_data      <= w_data_nxt;
            r_busy      <= w_busy_nxt;
            r_cfg_done  <= w_cfg_done_nxt;
            r_cfg_error <= w_cfg_error_nxt;
        end
    end

    // Delay counter, table index and retry count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 32'd0;
            r_index <= 4'd0;
            r_retry <= 8'd0;
        end else begin
            if (w_in_delay && (w_state_nxt == r_state)) r_cnt <= r_cnt + 32'd1;
            else                                       r_cnt <= 32'd0;
            if (w_start_ok)                                               r_index <= 4'd0;
            else if ((r_state == S_WAIT) && w_ack && (r_index != LAST_IDX)) r_index <= r_index + 4'd1;
            else                                                          r_index <= r_index;
            if (w_start_ok)                                 r_retry <= 8'd0;
            else if (w_in_wait && w_ack)                    r_retry <= 8'd0;
            else if (w_in_wait && i2c_done && (r_retry < RETRY_MAX)) r_retry <= r_retry + 8'd1;
            else                                            r_retry <= r_retry;
        end
    end

    assign i2c_req   = r_req;
    assign i2c_data  = r_data;
    assign busy      = r_busy;
    assign cfg_done  = r_cfg_done;
    assign cfg_error = r_cfg_error;
endmodule

// File: tb/tb_audio_codec_config.sv
// Scoreboard bench for audio_codec_config: a table-walking reference model predicts every I2C request,
// an I2C responder ACKs/NACKs 5 cycles after each request, and a monitor checks requests as they appear.
module tb_audio_codec_config;
    localparam int         PD       = 4;
    localparam int         BO       = 3;
    localparam int         MR       = 3;
    localparam int         RESP_LAT = 5;
    localparam logic [6:0] ADDR     = 7'h1A;
    localparam logic [15:0] TBL [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                                         16'h0A00, 16'h0C00, 16'h0E01, 16'h1000, 16'h1201};

    typedef struct {
        logic [23:0] data;
        int          gap;
        logic        cfgd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        vol_wr = 1'b0;
    logic [6:0]  vol_val = 7'd0;
    logic        i2c_req;
    logic [23:0] i2c_data;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;

    exp_t        exp_q[$];
    bit          nack_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ref_cyc = 0;
    int          done_cyc = -10;
    int          resp_due = 0;
    bit          resp_pending = 1'b0;
    bit          inject = 1'b0;
    bit          prev_req = 1'b0;
    logic [23:0] held = 24'd0;

    audio_codec_config #(
        .DEVICE_ADDR(ADDR), .POWERUP_DELAY(PD), .BACKOFF(BO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .i2c_req(i2c_req), .i2c_data(i2c_data),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy), .cfg_done(cfg_done),
        .cfg_error(cfg_error), .vol_wr(vol_wr), .vol_val(vol_val)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising request is popped from the scoreboard and compared.
    initial forever begin
        @(negedge clk);
        if (i2c_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: actual data=%06h required no request", i2c_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("req_data", i2c_data, mon_e.data);
                chk("req_gap", cyc - ref_cyc, mon_e.gap);
                chk("req_cfg_done", cfg_done, mon_e.cfgd);
                chk("req_busy", busy, 1'b1);
            end
            held         = i2c_data;
            resp_pending = 1'b1;
            resp_due     = cyc + RESP_LAT;
        end else if (i2c_req) begin
            chk("req_stable", i2c_data, held);
        end else begin
            resp_pending = 1'b0;
        end
        if (done_cyc == cyc - 1) chk("req_after_done", i2c_req, 1'b0);
        prev_req = i2c_req;
    end

    // I2C responder: completes each transfer RESP_LAT cycles after the request rose.
    initial forever begin
        @(posedge clk);
        #1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (inject) begin
            i2c_done = 1'b1;
            inject   = 1'b0;
        end else if (resp_pending && (cyc == resp_due) && i2c_req) begin
            i2c_done     = 1'b1;
            i2c_nack     = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
            done_cyc     = cyc;
            ref_cyc      = cyc;
            resp_pending = 1'b0;
        end
    end

    // Reference model: walk the table, one expected request per attempt, deciding ACK/NACK per attempt.
    task automatic build_expect(input int mode, input int n_idx, input int n_cnt, output bit err);
        int gap;
        int retries;
        bit nk;
        gap = PD + 2;
        err = 1'b0;
        for (int idx = 0; idx < 11; idx++) begin
            retries = 0;
            nk = 1'b1;
            while (nk && !err) begin
                exp_q.push_back('{data: {ADDR, 1'b0, TBL[idx]}, gap: gap, cfgd: 1'b0});
                case (mode)
                    0:       nk = 1'b0;
                    1:       nk = (idx == n_idx) && (retries < n_cnt);
                    default: nk = ($urandom_range(0, 3) == 0);
                endcase
                nack_q.push_back(nk);
                if (nk) begin
                    retries++;
                    gap = BO + 2;
                    if (retries > MR) err = 1'b1;
                end else begin
                    gap = 2;
                end
            end
            if (err) break;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start   = 1'b1;
        ref_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_cfg(input string tag, input int mode, input int n_idx, input int n_cnt, input bit extras);
        bit err;
        bit seen;
        logic [6:0] vol_last;
        build_expect(mode, n_idx, n_cnt, err);
        vol_last = 7'h60;
`ifdef AUDIO_CFG_VOLUME_EN
        if (extras && !err) begin
            exp_q.push_back('{data: {ADDR, 1'b0, 16'h0500 | {9'd0, vol_last}}, gap: 3, cfgd: 1'b1});
            nack_q.push_back(1'b0);
        end
`endif
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            start   = extras && ((k == 2) || (k == 30));
            vol_wr  = extras && ((k == 20) || (k == 40));
            vol_val = (k == 20) ? 7'h50 : vol_last;
            if (!seen && (cfg_done || cfg_error)) begin
                seen = 1'b1;
                chk({tag, "_fin_latency"}, cyc - done_cyc, 1);
            end
            if (seen && !busy && (exp_q.size() == 0) && !resp_pending) break;
        end
        start  = 1'b0;
        vol_wr = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: actual=no completion required=cfg_done or cfg_error", tag);
        end
        chk({tag, "_cfg_done"}, cfg_done, !err);
        chk({tag, "_cfg_error"}, cfg_error, err);
        chk({tag, "_req_idle"}, i2c_req, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        nack_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit err;
        bit found;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req", i2c_req, 1'b0);
        chk("rst_data", i2c_data, 24'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_done", cfg_done, 1'b0);
        chk("rst_cfg_error", cfg_error, 1'b0);

        run_cfg("clean", 0, 0, 0, 1'b1);
        run_cfg("nack4x2", 1, 3, 2, 1'b0);
        run_cfg("nack1x4", 1, 0, 4, 1'b0);
        run_cfg("rerun", 0, 0, 0, 1'b0);
        for (int r = 0; r < 5; r++) run_cfg("rand", 2, 0, 0, 1'b0);

        // Reset in the middle of the sixth transfer, with an ignored start earlier in that run.
        build_expect(0, 0, 0, err);
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (i2c_req && (i2c_data == {ADDR, 1'b0, TBL[5]})) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("word6_reached", found, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req", i2c_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        nack_q.delete();
        resp_pending = 1'b0;
        @(negedge clk);
        inject = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_done_busy", busy, 1'b0);
            chk("idle_done_req", i2c_req, 1'b0);
            chk("idle_done_cfg", cfg_done, 1'b0);
        end
        run_cfg("after_rst", 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
